// File: rtl/alu_result_skid_if.sv
// Handshake bundle between an ALU result producer, the skid buffer and the
// writeback consumer, plus the buffer's status outputs.
interface alu_result_skid_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 16;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [RD_W-1:0]  in_rd;
  logic             in_regwrite;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [RD_W-1:0]  out_rd;
  logic             out_regwrite;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] xfer_count;

  // Environment side: producer, consumer and pipeline control
  modport master (
    output in_valid, in_data, in_rd, in_regwrite, out_ready, flush,
    input  in_ready, out_valid, out_data, out_rd, out_regwrite, occupancy, xfer_count
  );

  // Buffer side
  modport slave (
    input  in_valid, in_data, in_rd, in_regwrite, out_ready, flush,
    output in_ready, out_valid, out_data, out_rd, out_regwrite, occupancy, xfer_count
  );
endinterface

// File: rtl/alu_result_skid.sv
// Two-entry skid buffer for ALU results: main entry drives the outputs, the
// skid entry absorbs one result so in_ready can be fully registered.
module alu_result_skid #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_skid_if.slave  bus
);
  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [RD_W-1:0]  rd;
    logic             regwrite;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_entry = '{data: bus.in_data, rd: bus.in_rd, regwrite: bus.in_regwrite};
  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  // Next-state, entry movement and transfer counter
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    occ_d   = 2'd0;
    xfer_d  = xfer_q;

    if (out_xfer && (xfer_q != CNT_MAX)) begin
      xfer_d = xfer_q + CNT_W'(1);
    end

    if (bus.flush) begin
      // Main keeps its contents so out_* retain their last value
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_entry;
          end else if (in_xfer) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    unique case (state_d)
      ONE:     occ_d = 2'd1;
      FULL:    occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // State, storage and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occ_d;
      xfer_q      <= xfer_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = main_q.data;
  assign bus.out_rd       = main_q.rd;
  assign bus.out_regwrite = main_q.regwrite;
  assign bus.occupancy    = occ_q;
  assign bus.xfer_count   = xfer_q;
endmodule

// File: tb/tb_alu_result_skid.sv
// Scoreboard bench for alu_result_skid: accepted inputs are queued, a monitor
// pops and compares on every output transfer; directed checks cover status.
module tb_alu_result_skid;
  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       rd;
    logic             regwrite;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  alu_result_skid_if #(.WIDTH(WIDTH)) bus ();

  alu_result_skid #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue side: record accepted inputs, drop everything on flush or reset
  always @(negedge clk) begin : issue
    logic take;
    logic drop;
    ent_t e;
    take = bus.in_valid && bus.in_ready;
    drop = !rst || bus.flush;
    e    = '{data: bus.in_data, rd: bus.in_rd, regwrite: bus.in_regwrite};
    #1;
    if (drop) exp_q.delete();
    else if (take) exp_q.push_back(e);
  end

  // Monitor: compare each output transfer, and check stability while stalled
  logic hold_pend = 1'b0;
  ent_t held;
  always @(negedge clk) begin : monitor
    ent_t got;
    ent_t want;
    got = '{data: bus.out_data, rd: bus.out_rd, regwrite: bus.out_regwrite};
    if (bus.out_valid) begin
      if (hold_pend) chk("hold_stable", 64'(got), 64'(held));
      if (bus.out_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h expected no output", got);
        end else begin
          want = exp_q.pop_front();
          chk("out_entry", 64'(got), 64'(want));
        end
      end else begin
        hold_pend = 1'b1;
        held      = got;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [WIDTH-1:0] d, input logic [4:0] r, input logic w);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_rd       = r;
    bus.in_regwrite = w;
    step();
    bus.in_valid    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_out_data"},  64'(bus.out_data), 64'(0));
    chk({tag, "_out_rd"},    64'(bus.out_rd), 64'(0));
    chk({tag, "_out_rw"},    64'(bus.out_regwrite), 64'(0));
    chk({tag, "_occ"},       64'(bus.occupancy), 64'(0));
    chk({tag, "_xfer"},      64'(bus.xfer_count), 64'(0));
  endtask

  initial begin
    int drops;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_rd       = '0;
    bus.in_regwrite = 1'b0;
    bus.out_ready   = 1'b0;
    bus.flush       = 1'b0;

    // Reset
    rst = 1'b0;
    step();
    step();
    chk_reset_vals("rst0");
    rst = 1'b1;
    step();

    // Single result, latency 1
    bus.out_ready = 1'b1;
    put(32'h0000_00A5, 5'd3, 1'b1);
    chk("lat_valid", 64'(bus.out_valid), 64'(1));
    chk("lat_data",  64'(bus.out_data), 64'h0000_00A5);
    chk("lat_rd",    64'(bus.out_rd), 64'(3));
    step();
    chk("single_xfer",   64'(bus.xfer_count), 64'(1));
    chk("single_occ",    64'(bus.occupancy), 64'(0));
    chk("single_retain", 64'(bus.out_data), 64'h0000_00A5);

    // Backpressure fills the skid entry
    bus.out_ready = 1'b0;
    put(32'h11, 5'd1, 1'b1);
    chk("one_occ", 64'(bus.occupancy), 64'(1));
    put(32'h22, 5'd2, 1'b0);
    chk("full_occ",      64'(bus.occupancy), 64'(2));
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_data",     64'(bus.out_data), 64'h11);
    repeat (3) step();
    chk("stall_data", 64'(bus.out_data), 64'h11);
    bus.out_ready = 1'b1;
    step();
    chk("drain_data", 64'(bus.out_data), 64'h22);
    chk("drain_occ",  64'(bus.occupancy), 64'(1));
    step();
    chk("drain_xfer", 64'(bus.xfer_count), 64'(3));
    chk("drain_empty", 64'(bus.out_valid), 64'(0));

    // Streaming at full rate
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready !== 1'b1) drops++;
      put(32'hC000_0000 + 32'(i), 5'(i), i[0]);
    end
    step();
    step();
    chk("stream_ready_drops", 64'(drops), 64'(0));
    chk("stream_xfer",        64'(bus.xfer_count), 64'(103));

    // Flush while FULL, with an input offered
    bus.out_ready = 1'b0;
    put(32'h33, 5'd4, 1'b1);
    put(32'h44, 5'd5, 1'b1);
    chk("pre_flush_occ", 64'(bus.occupancy), 64'(2));
    bus.flush       = 1'b1;
    put(32'h55, 5'd6, 1'b1);
    bus.flush       = 1'b0;
    chk("flush_occ",      64'(bus.occupancy), 64'(0));
    chk("flush_valid",    64'(bus.out_valid), 64'(0));
    chk("flush_in_ready", 64'(bus.in_ready), 64'(1));
    chk("flush_retain",   64'(bus.out_data), 64'h33);
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Flush in ONE discards a same-cycle accepted input
    bus.out_ready = 1'b0;
    put(32'h66, 5'd7, 1'b0);
    bus.flush = 1'b1;
    put(32'h77, 5'd8, 1'b1);
    bus.flush = 1'b0;
    chk("flush1_occ", 64'(bus.occupancy), 64'(0));
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("flush1_xfer", 64'(bus.xfer_count), 64'(103));

    // Output transfer in a flush cycle still counts
    put(32'h88, 5'd9, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flushx_xfer", 64'(bus.xfer_count), 64'(104));
    chk("flushx_occ",  64'(bus.occupancy), 64'(0));
    step();

    // Reset while FULL beats flush and transfers; no effect before the edge
    bus.out_ready = 1'b0;
    put(32'hAA, 5'd10, 1'b1);
    put(32'hBB, 5'd11, 1'b0);
    #1;
    rst           = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("async_occ",   64'(bus.occupancy), 64'(2));
    chk("async_valid", 64'(bus.out_valid), 64'(1));
    chk("async_data",  64'(bus.out_data), 64'hAA);
    chk("async_xfer",  64'(bus.xfer_count), 64'(104));
    step();
    chk_reset_vals("rstfull");
    rst           = 1'b1;
    bus.flush     = 1'b0;
    step();

    // Transfer counter saturation
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      put(32'(i) ^ 32'h5A5A_0000, 5'(i), i[1]);
    end
    step();
    step();
    chk("sat_reach", 64'(bus.xfer_count), 64'hFFFF);
    put(32'hDEAD_BEEF, 5'd31, 1'b1);
    step();
    step();
    chk("sat_hold", 64'(bus.xfer_count), 64'hFFFF);
    chk("sat_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
